// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM receiver stages.
package ofdm_pkg;

   // Cyclic-prefix strip sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CP   = 2'd1,
      ST_BODY = 2'd2
   } cp_state_t;

   // Default prefix lengths (normal / extended).
   localparam int unsigned CP_SHORT_DEF  = 16;
   localparam int unsigned CP_LONG_DEF   = 32;

   // Default sample width for the generic Avalon-ST beat.
   localparam int unsigned ST_DATA_W_DEF = 32;

   // One Avalon-ST beat with packet framing and error qualifier.
   typedef struct packed {
      logic [ST_DATA_W_DEF-1:0] data;
      logic                     sop;
      logic                     eop;
      logic                     error;
   } st_beat_t;

   // Bits needed to hold values 0..n-1 (never less than 1).
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/ofdm_st_out_reg.sv
// One-deep Avalon-ST output register: accepts a new beat whenever the
// slot is empty or being drained, holds data/flags stable while stalled.
module ofdm_st_out_reg
   import ofdm_pkg::*;
#(
   parameter type beat_t = st_beat_t
) (
   input  logic  clock_clk,
   input  logic  reset_reset,
   input  logic  in_load,
   input  beat_t in_beat,
   output logic  in_ready,
   output logic  out_valid,
   input  logic  out_ready,
   output beat_t out_beat
);

   assign in_ready = !out_valid || out_ready;

   // Load or drain the single output slot; hold everything while stalled.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_valid <= 1'b0;
         out_beat  <= '0;
      end else if (in_ready) begin
         out_valid <= in_load;
         if (in_load) out_beat <= in_beat;
      end
   end

endmodule

// File: rtl/ofdm_cp_strip.sv
// Cyclic-prefix removal: drops the CP of each OFDM symbol in an input
// packet and emits every NFFT-sample body as its own output packet.
module ofdm_cp_strip
   import ofdm_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NFFT     = 64,
   parameter int unsigned CP_SHORT = CP_SHORT_DEF,
   parameter int unsigned CP_LONG  = CP_LONG_DEF,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              clock_clk,
   input  logic              reset_reset,
   input  logic              cfg_cp_long,
   input  logic [DATA_W-1:0] asi_in0_data,
   input  logic              asi_in0_valid,
   output logic              asi_in0_ready,
   input  logic              asi_in0_startofpacket,
   input  logic              asi_in0_endofpacket,
   output logic [DATA_W-1:0] aso_out0_data,
   output logic              aso_out0_valid,
   input  logic              aso_out0_ready,
   output logic              aso_out0_startofpacket,
   output logic              aso_out0_endofpacket,
   output logic              aso_out0_error,
   output logic [CNT_W-1:0]  stat_sym_count,
   output logic              stat_trunc
);

   localparam int unsigned     SC_W     = cnt_width(CP_LONG + NFFT);
   localparam logic [SC_W-1:0] CP_S_LEN = SC_W'(CP_SHORT);
   localparam logic [SC_W-1:0] CP_L_LEN = SC_W'(CP_LONG);
   localparam logic [SC_W-1:0] LAST_OFS = SC_W'(NFFT - 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      logic              error;
   } beat_t;

   cp_state_t       state;
   logic [SC_W-1:0] samp_cnt;
   logic [SC_W-1:0] samp_cnt_inc;
   logic [SC_W-1:0] cp_len;
   logic [SC_W-1:0] cp_len_nxt;
   logic [SC_W-1:0] body_last_cnt;
   logic            in_ready;
   logic            accept;
   logic            body_last;
   logic            fwd_load;
   beat_t           fwd_beat;
   beat_t           out_beat;

   assign asi_in0_ready = in_ready;
   assign accept        = asi_in0_valid && in_ready;
   assign cp_len_nxt    = cfg_cp_long ? CP_L_LEN : CP_S_LEN;
   assign samp_cnt_inc  = samp_cnt + SC_W'(1);
   assign body_last_cnt = cp_len + LAST_OFS;
   assign body_last     = (samp_cnt == body_last_cnt);

   // Build the beat to forward when a body sample is accepted.
   always_comb begin
      fwd_load       = 1'b0;
      fwd_beat       = '0;
      fwd_beat.data  = asi_in0_data;
      if (accept && state == ST_BODY && !asi_in0_startofpacket) begin
         fwd_load       = 1'b1;
         fwd_beat.sop   = (samp_cnt == cp_len);
         fwd_beat.eop   = body_last || asi_in0_endofpacket;
         fwd_beat.error = asi_in0_endofpacket && !body_last;
      end
   end

   // Symbol sequencing, prefix-length latch and statistics.
   always_ff @(posedge clock_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state          <= ST_IDLE;
         samp_cnt       <= '0;
         cp_len         <= '0;
         stat_sym_count <= '0;
         stat_trunc     <= 1'b0;
      end else begin
         stat_trunc <= 1'b0;
         if (accept) begin
            if (asi_in0_startofpacket) begin
               // sop in CP/BODY abandons the current symbol and restarts here
               if (state != ST_IDLE) stat_trunc <= 1'b1;
               cp_len   <= cp_len_nxt;
               samp_cnt <= SC_W'(1);
               if (asi_in0_endofpacket) begin
                  stat_trunc <= 1'b1;
                  state      <= ST_IDLE;
               end else if (cp_len_nxt == SC_W'(1)) begin
                  state <= ST_BODY;
               end else begin
                  state <= ST_CP;
               end
            end else begin
               case (state)
                  ST_CP: begin
                     samp_cnt <= samp_cnt_inc;
                     if (asi_in0_endofpacket) begin
                        stat_trunc <= 1'b1;
                        state      <= ST_IDLE;
                     end else if (samp_cnt_inc == cp_len) begin
                        state <= ST_BODY;
                     end
                  end
                  ST_BODY: begin
                     if (body_last) begin
                        stat_sym_count <= stat_sym_count + CNT_W'(1);
                        samp_cnt       <= '0;
                        state          <= asi_in0_endofpacket ? ST_IDLE : ST_CP;
                     end else if (asi_in0_endofpacket) begin
                        stat_trunc <= 1'b1;
                        state      <= ST_IDLE;
                     end else begin
                        samp_cnt <= samp_cnt_inc;
                     end
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   ofdm_st_out_reg #(
      .beat_t (beat_t)
   ) u_out_reg (
      .clock_clk   (clock_clk),
      .reset_reset (reset_reset),
      .in_load     (fwd_load),
      .in_beat     (fwd_beat),
      .in_ready    (in_ready),
      .out_valid   (aso_out0_valid),
      .out_ready   (aso_out0_ready),
      .out_beat    (out_beat)
   );

   assign aso_out0_data          = out_beat.data;
   assign aso_out0_startofpacket = out_beat.sop;
   assign aso_out0_endofpacket   = out_beat.eop;
   assign aso_out0_error         = out_beat.error;

endmodule
